// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around an external 4-bit ALU: accepts one command at a time,
// updates an accumulator (single-cycle ALU ops, LOAD/READ, 4-cycle shift-add MUL) and returns a response.
module alu_seq_ctrl #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic [3:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_READ = 4'b1010;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;

    state_t     state;
    logic [3:0] acc_reg;
    logic [3:0] op_q;
    logic [3:0] data_q;
    logic [3:0] p;
    logic       carry;
    logic       err;
    logic [1:0] mul_idx;

    // Command decode, evaluated on the incoming opcode in IDLE.
    logic       cmd_is_alu;
    logic       cmd_is_mul;
    logic       cmd_is_load;
    logic       cmd_is_read;

    always_comb begin
        cmd_is_alu  = (cmd_op[3] == 1'b0) && (cmd_op[2:0] <= 3'd5);
        cmd_is_mul  = MUL_EN && (cmd_op == OP_MUL);
        cmd_is_load = (cmd_op == OP_LOAD);
        cmd_is_read = (cmd_op == OP_READ);
    end

    // Shift-add multiply step: acc<<i is the partial term, acc<<(i+1) feeds the next cycle.
    logic [7:0] acc_shift;
    logic [3:0] b_next;
    logic       mul_bit;
    logic       shift_lost;
    logic [3:0] p_next;

    always_comb begin
        acc_shift  = {4'b0000, acc_reg} << mul_idx;
        b_next     = acc_reg << ({1'b0, mul_idx} + 3'd1);
        mul_bit    = data_q[mul_idx];
        shift_lost = (acc_shift[7:4] != 4'b0000);
        p_next     = mul_bit ? alu_out : p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc_reg <= 4'h0;
            op_q    <= 4'h0;
            data_q  <= 4'h0;
            p       <= 4'h0;
            carry   <= 1'b0;
            err     <= 1'b0;
            mul_idx <= 2'd0;
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_sel <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        carry  <= 1'b0;
                        err    <= 1'b0;
                        if (cmd_is_alu) begin
                            state   <= S_EXEC;
                            alu_a   <= acc_reg;
                            alu_b   <= cmd_data;
                            alu_sel <= cmd_op[2:0];
                        end else if (cmd_is_mul) begin
                            state   <= S_MUL;
                            p       <= 4'h0;
                            mul_idx <= 2'd0;
                            alu_a   <= 4'h0;
                            alu_b   <= acc_reg;
                            alu_sel <= 3'b000;
                        end else begin
                            state <= S_RESP;
                            if (cmd_is_load) begin
                                acc_reg <= cmd_data;
                            end
                            err <= !(cmd_is_load || cmd_is_read);
                        end
                    end
                end

                S_EXEC: begin
                    acc_reg <= alu_out;
                    carry   <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_carry : 1'b0;
                    alu_a   <= 4'h0;
                    alu_b   <= 4'h0;
                    alu_sel <= 3'b000;
                    state   <= S_RESP;
                end

                S_MUL: begin
                    p       <= p_next;
                    mul_idx <= mul_idx + 2'd1;
                    if (mul_bit) begin
                        carry <= carry | alu_carry | shift_lost;
                    end
                    if (mul_idx == 2'd3) begin
                        acc_reg <= p_next;
                        alu_a   <= 4'h0;
                        alu_b   <= 4'h0;
                        alu_sel <= 3'b000;
                        state   <= S_RESP;
                    end else begin
                        alu_a   <= p_next;
                        alu_b   <= b_next;
                        alu_sel <= 3'b000;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Accumulator only changes on the edge entering RESP, so the response fields are stable there.
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = acc_reg;
    assign rsp_zero  = (acc_reg == 4'h0);
    assign rsp_carry = carry;
    assign rsp_err   = err;
    assign acc       = acc_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU attached to each instance.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [3:0] cmd_op, cmd_data, rsp_data, alu_a, alu_b, alu_out, acc;
    logic       rsp_carry, rsp_zero, rsp_err, alu_carry;
    logic [2:0] alu_sel;

    logic       n_cmd_valid, n_cmd_ready, n_rsp_valid, n_rsp_ready;
    logic [3:0] n_cmd_op, n_cmd_data, n_rsp_data, n_alu_a, n_alu_b, n_alu_out, n_acc;
    logic       n_rsp_carry, n_rsp_zero, n_rsp_err, n_alu_carry;
    logic [2:0] n_alu_sel;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] snap_a, snap_b;
    logic [2:0] snap_sel;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] sel);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~(a | b)};
            default: return 5'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out}     = alu_model(alu_a, alu_b, alu_sel);
    assign {n_alu_carry, n_alu_out} = alu_model(n_alu_a, n_alu_b, n_alu_sel);

    alu_seq_ctrl #(.MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .acc(acc)
    );

    alu_seq_ctrl #(.MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready), .cmd_op(n_cmd_op), .cmd_data(n_cmd_data),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_data(n_rsp_data),
        .rsp_carry(n_rsp_carry), .rsp_zero(n_rsp_zero), .rsp_err(n_rsp_err),
        .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_sel(n_alu_sel),
        .alu_out(n_alu_out), .alu_carry(n_alu_carry), .acc(n_acc)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, then wait (bounded) for rsp_valid and check the latency.
    task automatic send(input string tag, input logic [3:0] op, input logic [3:0] data,
                        input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".cmd_ready"}, 8'(cmd_ready), 8'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        snap_a    = alu_a;
        snap_b    = alu_b;
        snap_sel  = alu_sel;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 8'(lat), 8'(exp_lat));
        $display("cmd %s op=%h data=%h latency=%0d rsp_data=%h carry=%b zero=%b err=%b",
                 tag, op, data, lat, rsp_data, rsp_carry, rsp_zero, rsp_err);
    endtask

    task automatic expect_rsp(input string tag, input logic [3:0] d, input logic c,
                              input logic z, input logic e);
        chk({tag, ".rsp_valid"}, 8'(rsp_valid), 8'h1);
        chk({tag, ".rsp_data"},  8'(rsp_data),  8'(d));
        chk({tag, ".rsp_carry"}, 8'(rsp_carry), 8'(c));
        chk({tag, ".rsp_zero"},  8'(rsp_zero),  8'(z));
        chk({tag, ".rsp_err"},   8'(rsp_err),   8'(e));
        chk({tag, ".alu_idle"},  {alu_sel, alu_a | alu_b}, 8'h00);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"},  8'(rsp_valid), 8'h0);
        chk({tag, ".ready_back"}, 8'(cmd_ready), 8'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 4'h0; cmd_data = 4'h0; rsp_ready = 1'b0;
        n_cmd_valid = 1'b0; n_cmd_op = 4'h0; n_cmd_data = 4'h0; n_rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset.rsp_valid", 8'(rsp_valid), 8'h0);
        chk("reset.rsp_data",  8'(rsp_data),  8'h0);
        chk("reset.rsp_carry", 8'(rsp_carry), 8'h0);
        chk("reset.rsp_zero",  8'(rsp_zero),  8'h1);
        chk("reset.rsp_err",   8'(rsp_err),   8'h0);
        chk("reset.alu",       {alu_sel, alu_a | alu_b}, 8'h00);
        chk("reset.cmd_ready", 8'(cmd_ready), 8'h1);
        chk("reset.acc",       8'(acc),       8'h0);
        rst_n = 1'b1;

        send("load9", 4'h8, 4'h9, 0);
        expect_rsp("load9", 4'h9, 1'b0, 1'b0, 1'b0);
        send("add9", 4'h0, 4'h9, 1);
        chk("add9.alu_a", 8'(snap_a), 8'h9);
        chk("add9.alu_b", 8'(snap_b), 8'h9);
        chk("add9.alu_sel", 8'(snap_sel), 8'h0);
        expect_rsp("add9", 4'h2, 1'b1, 1'b0, 1'b0);

        send("load3a", 4'h8, 4'h3, 0);
        expect_rsp("load3a", 4'h3, 1'b0, 1'b0, 1'b0);
        send("sub5", 4'h1, 4'h5, 1);
        chk("sub5.alu_sel", 8'(snap_sel), 8'h1);
        expect_rsp("sub5", 4'hE, 1'b1, 1'b0, 1'b0);
        send("load3b", 4'h8, 4'h3, 0);
        expect_rsp("load3b", 4'h3, 1'b0, 1'b0, 1'b0);
        send("sub3", 4'h1, 4'h3, 1);
        expect_rsp("sub3", 4'h0, 1'b0, 1'b1, 1'b0);

        send("load3c", 4'h8, 4'h3, 0);
        expect_rsp("load3c", 4'h3, 1'b0, 1'b0, 1'b0);
        send("mul5", 4'h9, 4'h5, 4);
        chk("mul5.alu_a0", 8'(snap_a), 8'h0);
        chk("mul5.alu_b0", 8'(snap_b), 8'h3);
        expect_rsp("mul5", 4'hF, 1'b0, 1'b0, 1'b0);
        send("load6", 4'h8, 4'h6, 0);
        expect_rsp("load6", 4'h6, 1'b0, 1'b0, 1'b0);
        send("mul3", 4'h9, 4'h3, 4);
        expect_rsp("mul3", 4'h2, 1'b1, 1'b0, 1'b0);

        send("loadC", 4'h8, 4'hC, 0);
        expect_rsp("loadC", 4'hC, 1'b0, 1'b0, 1'b0);
        send("and6", 4'h2, 4'h6, 1);
        expect_rsp("and6", 4'h4, 1'b0, 1'b0, 1'b0);
        send("or1", 4'h3, 4'h1, 1);
        expect_rsp("or1", 4'h5, 1'b0, 1'b0, 1'b0);
        send("xorF", 4'h4, 4'hF, 1);
        expect_rsp("xorF", 4'hA, 1'b0, 1'b0, 1'b0);
        send("illegal7", 4'h7, 4'h3, 0);
        expect_rsp("illegal7", 4'hA, 1'b0, 1'b0, 1'b1);
        send("read", 4'hA, 4'h5, 0);
        expect_rsp("read", 4'hA, 1'b0, 1'b0, 1'b0);

        // Backpressure: response must hold while a new command is offered and ignored.
        send("loadF", 4'h8, 4'hF, 0);
        expect_rsp("loadF", 4'hF, 1'b0, 1'b0, 1'b0);
        send("nor0", 4'h5, 4'h0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold.rsp_valid", 8'(rsp_valid), 8'h1);
            chk("hold.rsp_data",  8'(rsp_data),  8'h0);
            chk("hold.cmd_ready", 8'(cmd_ready), 8'h0);
            cmd_valid = 1'b1; cmd_op = 4'h8; cmd_data = 4'h5;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("hold.acc", 8'(acc), 8'h0);
        expect_rsp("nor0", 4'h0, 1'b0, 1'b1, 1'b0);
        send("load1", 4'h8, 4'h1, 0);
        expect_rsp("load1", 4'h1, 1'b0, 1'b0, 1'b0);

        // Reset pulse in MUL cycle 2.
        send("load7", 4'h8, 4'h7, 0);
        expect_rsp("load7", 4'h7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'h9; cmd_data = 4'h7;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.rsp_valid", 8'(rsp_valid), 8'h0);
        chk("abort.acc",       8'(acc),       8'h0);
        chk("abort.alu",       {alu_sel, alu_a | alu_b}, 8'h00);
        chk("abort.cmd_ready", 8'(cmd_ready), 8'h1);
        chk("abort.rsp_zero",  8'(rsp_zero),  8'h1);
        @(negedge clk);
        chk("abort.still_idle", 8'(rsp_valid), 8'h0);
        rst_n = 1'b1;
        $display("reset pulse during MUL cycle 2 applied");
        send("read0", 4'hA, 4'h0, 0);
        expect_rsp("read0", 4'h0, 1'b0, 1'b1, 1'b0);

        // MUL_EN=0 instance: MUL must come back as an illegal command.
        @(negedge clk);
        n_cmd_valid = 1'b1; n_cmd_op = 4'h8; n_cmd_data = 4'h3;
        @(negedge clk);
        n_cmd_valid = 1'b0;
        chk("nomul.load.valid", 8'(n_rsp_valid), 8'h1);
        chk("nomul.load.data",  8'(n_rsp_data),  8'h3);
        n_rsp_ready = 1'b1;
        @(negedge clk);
        n_rsp_ready = 1'b0;
        n_cmd_valid = 1'b1; n_cmd_op = 4'h9; n_cmd_data = 4'h5;
        @(negedge clk);
        n_cmd_valid = 1'b0;
        chk("nomul.mul.valid", 8'(n_rsp_valid), 8'h1);
        chk("nomul.mul.err",   8'(n_rsp_err),   8'h1);
        chk("nomul.mul.data",  8'(n_rsp_data),  8'h3);
        chk("nomul.mul.carry", 8'(n_rsp_carry), 8'h0);
        $display("cmd nomul.mul rsp_data=%h err=%b", n_rsp_data, n_rsp_err);
        n_rsp_ready = 1'b1;
        @(negedge clk);
        n_rsp_ready = 1'b0;
        chk("nomul.ready_back", 8'(n_cmd_ready), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
